// File: rtl/vending_ctrl_n.sv
// Vending controller: coin credit, per-item dispense, dime/nickel change, 4-digit 7-seg credit display.
// Optional quarter coin input is enabled by defining VEND_QUARTER_EN.
module vending_ctrl_n #(
  parameter int N_ITEMS = 2,
  parameter int PRICE_W = 8,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES = {8'd25, 8'd20},
  parameter int MAX_CREDIT = 95,
  parameter int REFRESH_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               nickel,
  input  logic               dime,
`ifdef VEND_QUARTER_EN
  input  logic               quarter,
`endif
  input  logic               cancel,
  input  logic [N_ITEMS-1:0] sel,
  output logic [N_ITEMS-1:0] dispense,
  output logic               return_dime,
  output logic               return_nickel,
  output logic               busy,
  output logic [PRICE_W-1:0] credit,
  output logic [6:0]         seg7,
  output logic [3:0]         an
);

  localparam int SUM_W = PRICE_W + 2;

  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

  state_t state, stateNext;
  logic [PRICE_W-1:0] creditNext, selPrice;
  logic [N_ITEMS-1:0] dispNext, selOh;
  logic [SUM_W-1:0] coinSum, creditSum;
  logic coinIn, selHit, dimeNext, nickelNext, busyNext;
  logic [REFRESH_W-1:0] scanCnt;
  logic [1:0] digit, digitNext;
  logic [3:0] units, tens, hund;
  logic [6:0] segNext;

  function automatic logic [6:0] segEncode(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    coinSum = '0;
    coinIn  = nickel | dime;
    if (nickel) coinSum = coinSum + SUM_W'(5);
    if (dime)   coinSum = coinSum + SUM_W'(10);
`ifdef VEND_QUARTER_EN
    if (quarter) coinSum = coinSum + SUM_W'(25);
    coinIn = coinIn | quarter;
`endif
    creditSum = SUM_W'(credit) + coinSum;
  end

  // Scan from the top down so the lowest-index set bit wins.
  always_comb begin
    selHit   = 1'b0;
    selOh    = '0;
    selPrice = '0;
    for (int i = N_ITEMS - 1; i >= 0; i--) begin
      if (sel[i]) begin
        selHit   = 1'b1;
        selOh    = '0;
        selOh[i] = 1'b1;
        selPrice = PRICES[i*PRICE_W +: PRICE_W];
      end
    end
  end

  always_comb begin
    stateNext  = state;
    creditNext = credit;
    dispNext   = '0;
    dimeNext   = 1'b0;
    nickelNext = 1'b0;
    case (state)
      IDLE: begin
        if (!busy) begin
          if (creditSum > SUM_W'(MAX_CREDIT)) begin
            creditNext = PRICE_W'(creditSum);
            stateNext  = CHANGE;
          end else if (cancel) begin
            creditNext = PRICE_W'(creditSum);
            if (creditSum != '0) stateNext = CHANGE;
          end else if (coinIn) begin
            creditNext = PRICE_W'(creditSum);
          end else if (selHit && (credit >= selPrice)) begin
            creditNext = credit - selPrice;
            dispNext   = selOh;
            stateNext  = DISPENSE;
          end
        end
      end
      DISPENSE: stateNext = (credit != '0) ? CHANGE : IDLE;
      CHANGE: begin
        if (credit >= PRICE_W'(10)) begin
          dimeNext   = 1'b1;
          creditNext = credit - PRICE_W'(10);
        end else if (credit >= PRICE_W'(5)) begin
          nickelNext = 1'b1;
          creditNext = credit - PRICE_W'(5);
        end else begin
          creditNext = '0;
        end
        if (creditNext == '0) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Busy also covers the cycle in which the final change pulse is out.
    busyNext = (stateNext != IDLE) || dimeNext || nickelNext;
  end

  always_comb begin
    units     = 4'(credit % PRICE_W'(10));
    tens      = 4'((credit / PRICE_W'(10)) % PRICE_W'(10));
    hund      = 4'(credit / PRICE_W'(100));
    digitNext = (&scanCnt) ? digit + 2'd1 : digit;
    case (digitNext)
      2'd0:    segNext = segEncode(units);
      2'd1:    segNext = ((hund != 4'd0) || (tens != 4'd0)) ? segEncode(tens) : 7'h7F;
      2'd2:    segNext = (hund != 4'd0) ? segEncode(hund) : 7'h7F;
      default: segNext = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      credit        <= '0;
      dispense      <= '0;
      return_dime   <= 1'b0;
      return_nickel <= 1'b0;
      busy          <= 1'b0;
      scanCnt       <= '0;
      digit         <= 2'd0;
      an            <= 4'b1110;
      seg7          <= 7'b1000000;
    end else begin
      state         <= stateNext;
      credit        <= creditNext;
      dispense      <= dispNext;
      return_dime   <= dimeNext;
      return_nickel <= nickelNext;
      busy          <= busyNext;
      scanCnt       <= scanCnt + 1'b1;
      digit         <= digitNext;
      an            <= ~(4'b0001 << digitNext);
      seg7          <= segNext;
    end
  end

endmodule

// File: tb/tb_vending_ctrl_n.sv
// Self-checking bench for vending_ctrl_n: scoreboard of dispense/change events plus direct state checks.
module tb_vending_ctrl_n;

  logic clk = 1'b0;
  logic rst_n, nickel, dime, cancel;
`ifdef VEND_QUARTER_EN
  logic quarter;
`endif
  logic [1:0] sel, dispense;
  logic return_dime, return_nickel, busy;
  logic [7:0] credit;
  logic [6:0] seg7;
  logic [3:0] an;

  int n_checks = 0;
  int n_pass = 0;
  int cyc;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  vending_ctrl_n #(
    .N_ITEMS(2), .PRICE_W(8), .PRICES({8'd25, 8'd20}), .MAX_CREDIT(95), .REFRESH_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime),
`ifdef VEND_QUARTER_EN
    .quarter(quarter),
`endif
    .cancel(cancel), .sel(sel), .dispense(dispense), .return_dime(return_dime),
    .return_nickel(return_nickel), .busy(busy), .credit(credit), .seg7(seg7), .an(an)
  );

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic log_event(input logic [7:0] code);
    if (exp_q.size() == 0) check_eq("unexpected_evt", code, 0);
    else check_eq("evt_order", code, exp_q.pop_front());
  endtask

  // Event codes: 8'h40|dispense, 8'h10 dime returned, 8'h20 nickel returned.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dispense != 2'b00) log_event(8'h40 | {6'b0, dispense});
      if (return_dime) log_event(8'h10);
      if (return_nickel) log_event(8'h20);
    end
  end

  task automatic coin(input logic n, input logic d);
    @(negedge clk);
    nickel = n;
    dime = d;
    @(negedge clk);
    nickel = 1'b0;
    dime = 1'b0;
  endtask

  task automatic select(input logic [1:0] s);
    @(negedge clk);
    sel = s;
    @(negedge clk);
    sel = 2'b00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) check_eq("idle_timeout", busy, 0);
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'h12;
      1: return 7'h19;
      default: return 7'h7F;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int d;
    logic [3:0] exp_an;
    rst_n = 1'b0; nickel = 1'b0; dime = 1'b0; cancel = 1'b0; sel = 2'b00;
`ifdef VEND_QUARTER_EN
    quarter = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_credit", credit, 0);
    check_eq("rst_dispense", dispense, 0);
    check_eq("rst_rdime", return_dime, 0);
    check_eq("rst_rnickel", return_nickel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_an", an, 4'b1110);
    check_eq("rst_seg7", seg7, 7'b1000000);
    rst_n = 1'b1;

    // Exact price: 20 cents buys item 0 with no change.
    coin(0, 1); coin(0, 1);
    check_eq("credit20", credit, 20);
    exp_q.push_back(8'h41);
    select(2'b01);
    check_eq("disp0_pulse", dispense, 1);
    check_eq("disp0_busy", busy, 1);
    check_eq("disp0_credit", credit, 0);
    @(negedge clk);
    check_eq("disp0_clear", dispense, 0);
    check_eq("disp0_busy_low", busy, 0);

    // 35 cents, item 1 at 25 -> one dime back.
    coin(0, 1); coin(0, 1); coin(0, 1); coin(1, 0);
    check_eq("credit35", credit, 35);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h10);
    select(2'b10);
    check_eq("disp1_pulse", dispense, 2);
    check_eq("disp1_credit", credit, 10);
    wait_idle();
    check_eq("disp1_final", credit, 0);

    // Cancel with 15 cents: dime then nickel back-to-back.
    coin(1, 0); coin(1, 0); coin(1, 0);
    check_eq("credit15", credit, 15);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    @(negedge clk) cancel = 1'b1;
    @(negedge clk) cancel = 1'b0;
    check_eq("cancel_busy", busy, 1);
    check_eq("cancel_credit", credit, 15);
    @(negedge clk);
    check_eq("cancel_dime", return_dime, 1);
    check_eq("cancel_credit5", credit, 5);
    @(negedge clk);
    check_eq("cancel_nickel", return_nickel, 1);
    check_eq("cancel_nodime", return_dime, 0);
    check_eq("cancel_credit0", credit, 0);
    @(negedge clk);
    check_eq("cancel_busy_low", busy, 0);

    // Overflow: 90 + dime = 100 > 95 -> ten dimes back.
    for (int i = 0; i < 9; i++) coin(0, 1);
    check_eq("credit90", credit, 90);
    for (int i = 0; i < 10; i++) exp_q.push_back(8'h10);
    coin(0, 1);
    check_eq("over_credit", credit, 100);
    check_eq("over_busy", busy, 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (return_dime) cnt++;
    end
    check_eq("over_dimes", cnt, 10);
    @(negedge clk);
    check_eq("over_busy_low", busy, 0);
    check_eq("over_credit0", credit, 0);

    // Insufficient credit, then a coin during change is ignored.
    coin(1, 0); coin(1, 0); coin(1, 0);
    select(2'b01);
    check_eq("short_credit", credit, 15);
    check_eq("short_nodisp", dispense, 0);
    check_eq("short_busy", busy, 0);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    @(negedge clk) cancel = 1'b1;
    @(negedge clk) begin cancel = 1'b0; nickel = 1'b1; end
    @(negedge clk) nickel = 1'b0;
    wait_idle();
    check_eq("ignored_coin", credit, 0);

    // Display of 45 cents with a 4-cycle digit period.
    coin(0, 1); coin(0, 1); coin(0, 1); coin(0, 1); coin(1, 0);
    check_eq("credit45", credit, 45);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d = (cyc / 4) % 4;
      exp_an = ~(4'b0001 << d);
      check_eq("scan_an", an, exp_an);
      check_eq("scan_seg7", seg7, exp_seg(d));
    end

    @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vending_ctrl_n.md
# vending_ctrl_n

Parametrised vending controller: accepts coins into a credit register, dispenses one of N_ITEMS products at per-item prices, returns change as dime/nickel pulses, and drives a multiplexed 4-digit seven-segment display of the current credit in cents. It replaces the fixed two-product controller-plus-decoder pair at the top of the lab design. It sits directly under the board top-level, between the debounced button/coin inputs and the LED/7-seg pins.

## Interface
- N_ITEMS, 2, number of products (1..8)
- PRICE_W, 8, width of credit and price values in cents (7..10)
- PRICES, {8'd25, 8'd20}, packed prices; item i price = PRICES[i*PRICE_W +: PRICE_W]; every price must be a nonzero multiple of 5
- MAX_CREDIT, 95, highest credit accepted (multiple of 5, ≤ 999, < 2^PRICE_W)
- REFRESH_W, 16, width of display scan counter
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- nickel  in  1  single-cycle pulse, 5 cents
- dime  in  1  single-cycle pulse, 10 cents
- quarter  in  1  single-cycle pulse, 25 cents (only with VEND_QUARTER_EN)
- cancel  in  1  refund request, level sampled each cycle
- sel  in  N_ITEMS  product select, level sampled each cycle
- dispense  out  N_ITEMS  one-hot, one-cycle dispense pulse
- return_dime  out  1  one-cycle pulse per dime returned
- return_nickel  out  1  one-cycle pulse per nickel returned
- busy  out  1  high in DISPENSE/CHANGE; coin chute blocked
- credit  out  PRICE_W  current credit in cents
- seg7  out  7  segments {g,f,e,d,c,b,a}, active low
- an  out  4  digit enables, active low, one-hot

## Operation
- States: IDLE, DISPENSE, CHANGE. All outputs registered.
- IDLE, per cycle, in priority order:
  - Coins: sum of all coin pulses this cycle added to credit. If credit+sum > MAX_CREDIT, credit ← credit+sum and go to CHANGE (full refund).
  - cancel: go to CHANGE (coins in same cycle added first). If resulting credit is 0, stay IDLE.
  - sel: ignored in any cycle with a coin pulse or cancel. Otherwise take lowest-index set bit i; if credit ≥ price[i], credit ← credit − price[i], dispense[i] ← 1, go to DISPENSE; else no action (higher bits not considered).
- DISPENSE (1 cycle): dispense cleared; go to CHANGE if credit > 0, else IDLE.
- CHANGE, per cycle: credit ≥ 10 → return_dime pulse, credit −= 10; else credit ≥ 5 → return_nickel pulse, credit −= 5. When credit reaches 0, go to IDLE. Dimes always before nickels.
- Coins, sel, cancel ignored while busy = 1.
- Display: credit converted to 3 BCD digits; an[0..2] show units/tens/hundreds, leading zeros blanked (units always shown), an[3] always blank (seg7 = 7'h7F). Scan counter increments every cycle; digit index advances on counter wrap, order 0→1→2→3→0.

## Timing
- Reset (async assert, sync release): state IDLE, credit 0, dispense 0, return_* 0, busy 0, scan counter 0, an = 4'b1110, seg7 = 7'b1000000 ("0").
- Coin at edge k → credit updated after edge k.
- sel at edge k (sufficient credit) → dispense high for cycle k..k+1, busy high from k; change pulses begin the following cycle.
- Change: ceil of one pulse per cycle, back-to-back; 35 cents → dime, dime, dime, nickel on 4 consecutive cycles; busy falls the edge after the last pulse.
- Reset mid-CHANGE: outstanding change is lost; credit 0.
- Digit period = 2^REFRESH_W cycles.

## Configuration
- VEND_QUARTER_EN defined: quarter port present, adds 25 cents.
- Undefined: quarter port absent; only nickel and dime accepted; logic otherwise identical.

## Test plan
- Reset, then dime, dime, sel=01 (price 20) → dispense=01 one cycle, credit 0, no return pulses, busy high 1 cycle.
- Quarter + dime (sum 35), sel=10 (price 25) → dispense=10, then one return_dime, credit 0.
- Nickel ×3, cancel → return_dime, return_nickel on consecutive cycles, credit 0, no dispense.
- Credit 90, dime → credit 100 > 95 → ten return_dime pulses back-to-back, back to IDLE.
- Credit 15, sel=01 (price 20) → no dispense, credit stays 15; nickel pulse during a CHANGE sequence → ignored.
- Credit 45, REFRESH_W=2 → an cycles 1110,1101,1011,0111 every 4 cycles; seg7 shows "5","4",blank,blank.
